// File: rtl/circle_draw_unit_p.sv
// circle_draw_unit_p
// Midpoint circle rasteriser for the framebuffer drawing engine. It accepts a
// centre, radius and colour from the register bus and walks the first octant.
// Each step is mirrored into all eight octants. Every mirrored point inside
// the frame becomes one masked 32-bit word write on the de_* port. Points
// outside the frame are dropped, so the unit never produces a wrapped address.

module circle_draw_unit_p #(
    parameter int STRIDE   = 640,
    parameter int HEIGHT   = 480,
    parameter int PIX_BITS = 8,
    parameter int ADDR_W   = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              ack,
    output logic              busy,
    input  logic [15:0]       r0,
    input  logic [15:0]       r1,
    input  logic [15:0]       r2,
    input  logic [15:0]       r3,
    input  logic [15:0]       r4,
    input  logic [15:0]       r5,
    input  logic [15:0]       r6,
    input  logic [15:0]       r7,
    output logic              de_req,
    input  logic              de_ack,
    output logic [ADDR_W-1:0] de_addr,
    output logic [3:0]        de_nbyte,
    output logic              de_rnw,
    output logic [31:0]       de_w_data,
    input  logic [31:0]       de_r_data
);

    // Frame limits as signed values so that negative coordinates compare correctly
    localparam logic signed [17:0] STRIDE_S = 18'(STRIDE);
    localparam logic signed [17:0] HEIGHT_S = 18'(HEIGHT);
    localparam logic [31:0]        STRIDE_U = 32'(STRIDE);
    localparam logic [31:0]        BPP_U    = 32'(PIX_BITS / 8);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_STEP  = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;

    logic [15:0]         xc_r, yc_r, colour_r;
    logic [15:0]         xc_nxt_s, yc_nxt_s, colour_nxt_s;
    logic signed [17:0]  x_r, y_r, e_r;
    logic signed [17:0]  x_nxt_s, y_nxt_s, e_nxt_s;
    logic [2:0]          octant_r, octant_nxt_s;

    logic                ack_r, ack_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                de_req_r, de_req_nxt_s;
    logic [ADDR_W-1:0]   de_addr_r, de_addr_nxt_s;
    logic [3:0]          de_nbyte_r, de_nbyte_nxt_s;
    logic [31:0]         de_w_data_r, de_w_data_nxt_s;

    logic signed [17:0]  xc_s, yc_s;
    logic signed [17:0]  px_s, py_s;
    logic                clip_s;
    logic [31:0]         byte_addr_s;
    logic [3:0]          pix_nbyte_s;
    logic [31:0]         pix_data_s;

    logic                oct_last_s;
    logic [2:0]          octant_adv_s;
    state_t              state_adv_s;

    logic signed [17:0]  e_sub_s, x_inc_s, y_dec_s, e_adj_s;

    logic                unused_s;

    assign xc_s = signed'({2'b00, xc_r});
    assign yc_s = signed'({2'b00, yc_r});

    // Mirror the current (x, y) into the point belonging to the active octant
    always_comb begin
        px_s = xc_s + x_r;
        py_s = yc_s + y_r;
        case (octant_r)
            3'd0: begin px_s = xc_s + x_r; py_s = yc_s + y_r; end
            3'd1: begin px_s = xc_s + y_r; py_s = yc_s + x_r; end
            3'd2: begin px_s = xc_s + y_r; py_s = yc_s - x_r; end
            3'd3: begin px_s = xc_s + x_r; py_s = yc_s - y_r; end
            3'd4: begin px_s = xc_s - x_r; py_s = yc_s - y_r; end
            3'd5: begin px_s = xc_s - y_r; py_s = yc_s - x_r; end
            3'd6: begin px_s = xc_s - y_r; py_s = yc_s + x_r; end
            3'd7: begin px_s = xc_s - x_r; py_s = yc_s + y_r; end
            default: begin px_s = xc_s + x_r; py_s = yc_s + y_r; end
        endcase
    end

    assign clip_s = (px_s < 18'sd0) || (px_s >= STRIDE_S) ||
                    (py_s < 18'sd0) || (py_s >= HEIGHT_S);

    // Only meaningful for visible points, where px and py are known non-negative
    assign byte_addr_s = ((32'(py_s[16:0]) * STRIDE_U) + 32'(py_s[16:0] & 17'd0) +
                          32'(px_s[16:0])) * BPP_U;

    // Byte lane selection and colour replication for the configured pixel size
    always_comb begin
        if (PIX_BITS == 16) begin
            pix_nbyte_s = byte_addr_s[1] ? 4'b0011 : 4'b1100;
            pix_data_s  = {2{colour_r[15:0]}};
        end else begin
            pix_nbyte_s = ~(4'b0001 << byte_addr_s[1:0]);
            pix_data_s  = {4{colour_r[7:0]}};
        end
    end

    // After the eighth octant the algorithm steps; otherwise it mirrors the next octant
    assign oct_last_s   = (octant_r == 3'd7);
    assign octant_adv_s = oct_last_s ? 3'd0 : (octant_r + 3'd1);
    assign state_adv_s  = oct_last_s ? ST_STEP : ST_SETUP;

    // Midpoint error update terms for one step along the octant
    assign e_sub_s = e_r - (x_r + x_r + 18'sd1);
    assign x_inc_s = x_r + 18'sd1;
    assign y_dec_s = y_r - 18'sd1;
    assign e_adj_s = e_sub_s + y_dec_s + y_dec_s;

    // Next-state and next-output logic for the drawing sequencer
    always_comb begin
        state_nxt_s     = state_r;
        xc_nxt_s        = xc_r;
        yc_nxt_s        = yc_r;
        colour_nxt_s    = colour_r;
        x_nxt_s         = x_r;
        y_nxt_s         = y_r;
        e_nxt_s         = e_r;
        octant_nxt_s    = octant_r;
        ack_nxt_s       = 1'b0;
        de_req_nxt_s    = de_req_r;
        de_addr_nxt_s   = de_addr_r;
        de_nbyte_nxt_s  = de_nbyte_r;
        de_w_data_nxt_s = de_w_data_r;

        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    xc_nxt_s     = r0;
                    yc_nxt_s     = r1;
                    colour_nxt_s = r3;
                    x_nxt_s      = 18'sd0;
                    y_nxt_s      = signed'({2'b00, r2});
                    e_nxt_s      = signed'({2'b00, r2});
                    octant_nxt_s = 3'd0;
                    ack_nxt_s    = 1'b1;
                    state_nxt_s  = ST_SETUP;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end

            ST_SETUP: begin
                if (clip_s) begin
                    octant_nxt_s = octant_adv_s;
                    state_nxt_s  = state_adv_s;
                end else begin
                    de_req_nxt_s    = 1'b1;
                    de_addr_nxt_s   = byte_addr_s[ADDR_W+1:2];
                    de_nbyte_nxt_s  = pix_nbyte_s;
                    de_w_data_nxt_s = pix_data_s;
                    state_nxt_s     = ST_WRITE;
                end
            end

            ST_WRITE: begin
                if (de_ack) begin
                    de_req_nxt_s = 1'b0;
                    octant_nxt_s = octant_adv_s;
                    state_nxt_s  = state_adv_s;
                end else begin
                    de_req_nxt_s = 1'b1;
                end
            end

            ST_STEP: begin
                x_nxt_s = x_inc_s;
                if (e_sub_s < 18'sd0) begin
                    y_nxt_s = y_dec_s;
                    e_nxt_s = e_adj_s;
                end else begin
                    y_nxt_s = y_r;
                    e_nxt_s = e_sub_s;
                end
                if (x_inc_s > y_nxt_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SETUP;
                end
            end

            default: begin
                de_req_nxt_s = 1'b0;
                state_nxt_s  = ST_IDLE;
            end
        endcase

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State register; reset wins over everything, including a pending write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            xc_r        <= 16'd0;
            yc_r        <= 16'd0;
            colour_r    <= 16'd0;
            x_r         <= 18'sd0;
            y_r         <= 18'sd0;
            e_r         <= 18'sd0;
            octant_r    <= 3'd0;
            ack_r       <= 1'b0;
            busy_r      <= 1'b0;
            de_req_r    <= 1'b0;
            de_addr_r   <= '0;
            de_nbyte_r  <= 4'hF;
            de_w_data_r <= 32'd0;
        end else begin
            xc_r        <= xc_nxt_s;
            yc_r        <= yc_nxt_s;
            colour_r    <= colour_nxt_s;
            x_r         <= x_nxt_s;
            y_r         <= y_nxt_s;
            e_r         <= e_nxt_s;
            octant_r    <= octant_nxt_s;
            ack_r       <= ack_nxt_s;
            busy_r      <= busy_nxt_s;
            de_req_r    <= de_req_nxt_s;
            de_addr_r   <= de_addr_nxt_s;
            de_nbyte_r  <= de_nbyte_nxt_s;
            de_w_data_r <= de_w_data_nxt_s;
        end
    end

    assign ack       = ack_r;
    assign busy      = busy_r;
    assign de_req    = de_req_r;
    assign de_addr   = de_addr_r;
    assign de_nbyte  = de_nbyte_r;
    assign de_w_data = de_w_data_r;
    assign de_rnw    = 1'b0;

    // Reserved registers, read data and spare address/colour bits are intentionally unused
    assign unused_s = ^{r4, r5, r6, r7, de_r_data, byte_addr_s, colour_r};

endmodule

// File: doc/circle_draw_unit_p.md
# circle_draw_unit_p

Parametrised second-generation circle drawing unit for the framebuffer drawing engine. It takes a centre, a radius and a colour on the register bus, runs the integer midpoint circle algorithm, and emits one masked 32-bit word write per pixel on the drawing-engine (de_*) port. Over the first-generation unit it adds generic frame geometry, 8- or 16-bit pixels, screen clipping, synchronous reset and well-defined termination.

## Interface
- STRIDE, 640: frame width in pixels; also the row pitch.
- HEIGHT, 480: frame height in pixels.
- PIX_BITS, 8: pixel width; legal values are 8 and 16.
- ADDR_W, 18: de_addr width (32-bit word address).
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- req  in  1  start request from the register bus.
- ack  out  1  one-cycle request acknowledge.
- busy  out  1  high while a circle is in progress.
- r0  in  16  xc, centre x, unsigned.
- r1  in  16  yc, centre y, unsigned.
- r2  in  16  radius, unsigned (0..32767).
- r3  in  16  colour; bits [PIX_BITS-1:0] are used.
- r4..r7  in  16 each  reserved, ignored.
- de_req  out  1  write request.
- de_ack  in  1  write accepted.
- de_addr  out  ADDR_W  word address.
- de_nbyte  out  4  active-low byte enables.
- de_rnw  out  1  tied to 0 (writes only).
- de_w_data  out  32  colour replicated to every pixel slot.
- de_r_data  in  32  unused.

## Operation
- States: IDLE, SETUP, WRITE, STEP.
- IDLE:
  - When req is high, latch r0..r3 and set x=0, y=r2, e=r2 (signed, 18 bits).
  - Set octant=0 and go to SETUP.
  - req is ignored in every state other than IDLE.
- SETUP: form the point for the current octant from signed 18-bit coordinates (px,py):
  - Octants 0..7 give: (xc+x,yc+y), (xc+y,yc+x), (xc+y,yc-x), (xc+x,yc-y), (xc-x,yc-y), (xc-y,yc-x), (xc-y,yc+x), (xc-x,yc+y).
  - Clip test: the point is clipped if px<0, px>=STRIDE, py<0 or py>=HEIGHT. A clipped point skips WRITE and is treated as done.
  - For a visible point:
    - Byte address b = (py*STRIDE+px)*(PIX_BITS/8).
    - de_addr = b[ADDR_W+1:2].
    - PIX_BITS=8: de_nbyte clears only bit b[1:0]; de_w_data = {4{colour[7:0]}}.
    - PIX_BITS=16: de_nbyte = 4'b1100 when b[1]=0, else 4'b0011; de_w_data = {2{colour[15:0]}}.
- WRITE: hold de_req and all de_* outputs stable until de_ack is sampled high.
- Octant advance after a written or clipped point:
  - octant<7: octant+1, back to SETUP.
  - octant==7: octant=0, go to STEP.
- STEP:
  - e = e-(2x+1), then x = x+1.
  - If the new e<0: y = y-1, then e = e+2*(new y).
  - If new x > new y, go to IDLE; otherwise go to SETUP.
- Coincident points (x==0 or x==y) are written repeatedly; no suppression.
- radius 0 produces 8 writes to (xc,yc), or none if that point is clipped.
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE, ack 0, busy 0, de_req 0, de_addr 0, de_nbyte 4'hF, de_w_data 0.
- rst has priority in every state, including a write waiting in WRITE. The write is abandoned and de_req is low after that edge.
- ack:
  - Pulses high for exactly one cycle, the cycle after the edge where req was sampled in IDLE.
  - No ack is given for a req raised while busy.
- busy rises on the same edge as ack.
- Each written point takes 2 cycles plus the wait for de_ack: SETUP, then de_req high from the next edge.
- de_req falls on the edge that samples de_ack. de_ack arriving in the first WRITE cycle gives a one-cycle de_req.
- A clipped point costs one SETUP cycle.
- STEP takes 1 cycle.
- The final STEP returns to IDLE: busy falls on that edge. A req present in the next cycle is accepted.

## Test plan
- Reset mid-write: start r0=10,r1=10,r2=20 and hold de_ack=0 for 5 cycles in WRITE, then pulse rst -> de_req, busy and ack are 0 after that edge. A new req is acked.
- Zero radius, 8bpp: r0=10,r1=10,r2=0,r3=8'h5A, de_ack tied high -> 8 writes, each de_addr=1602, de_nbyte=4'b1011, de_w_data=32'h5A5A5A5A. Then busy drops.
- Small circle: r0=100,r1=100,r2=1 -> exactly 16 writes. The first 8 cover (100,101),(101,100),(101,100),(100,99),(100,99),(99,100),(99,100),(100,101); the last 8 are the 4 diagonals, each twice.
- Clipping: r0=0,r1=0,r2=5 -> only points with px>=0 and py>=0 are written. Writes never reach negative coordinates or wrap addresses. Total cycles are fewer than for an unclipped r=5 circle.
- 16bpp: PIX_BITS=16, r0=3,r1=0,r2=0,r3=16'hBEEF -> de_addr=1, de_nbyte=4'b0011, de_w_data=32'hBEEFBEEF.
- Handshake: de_ack delayed 0, 1 and 7 cycles at random -> de_addr, de_nbyte and de_w_data stay stable while de_req is high. req pulses during busy produce no ack.
